// File: rtl/instr_fetch_ctrl.sv
// Instruction fetch controller: loads the program memory from file, then walks
// the program through a 1-cycle registered read port and hands words to decode.
module instr_fetch_ctrl #(
   parameter int ADDR_W    = 9,
   parameter int INSTR_W   = 16,
   parameter int MEM_DEPTH = 400
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               fin_file,
   input  logic [INSTR_W-1:0] return_instr_line,
   output logic               read_file,
   output logic               read_memory,
   output logic [ADDR_W-1:0]  pos,
   input  logic               branch_en,
   input  logic [ADDR_W-1:0]  branch_target,
   input  logic               halt,
   input  logic               instr_ready,
   output logic               instr_valid,
   output logic [INSTR_W-1:0] instr_out,
   output logic [ADDR_W-1:0]  instr_pc,
   output logic [ADDR_W-1:0]  prog_len,
   output logic               done,
   output logic               pc_err
);

   // state | meaning
   // LOAD  | strobing read_file, counting words until fin_file or memory full
   // REQ   | read_memory high with pos=pc; memory latches data on the edge
   // CAP   | read data available; captured into instr_out on the edge
   // VALID | instr_out offered to decode, held until handshake
   // DONE  | fetch finished; terminal until reset
   typedef enum logic [2:0] {LOAD, REQ, CAP, VALID, DONE} state_t;

   localparam logic [ADDR_W-1:0] LAST_WORD = ADDR_W'(MEM_DEPTH - 1);
   localparam logic [ADDR_W-1:0] FULL_LEN  = ADDR_W'(MEM_DEPTH);

   state_t             state, state_nxt;
   logic [ADDR_W-1:0]  pc, pc_nxt;
   logic [ADDR_W-1:0]  prog_len_nxt, pos_nxt, instr_pc_nxt;
   logic [INSTR_W-1:0] instr_out_nxt;
   logic               read_file_nxt, read_memory_nxt, instr_valid_nxt, done_nxt, pc_err_nxt;
   logic [ADDR_W:0]    next_pc;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state       <= LOAD;
         pc          <= '0;
         prog_len    <= '0;
         read_file   <= 1'b0;
         read_memory <= 1'b0;
         pos         <= '0;
         instr_valid <= 1'b0;
         instr_out   <= '0;
         instr_pc    <= '0;
         done        <= 1'b0;
         pc_err      <= 1'b0;
      end else begin
         state       <= state_nxt;
         pc          <= pc_nxt;
         prog_len    <= prog_len_nxt;
         read_file   <= read_file_nxt;
         read_memory <= read_memory_nxt;
         pos         <= pos_nxt;
         instr_valid <= instr_valid_nxt;
         instr_out   <= instr_out_nxt;
         instr_pc    <= instr_pc_nxt;
         done        <= done_nxt;
         pc_err      <= pc_err_nxt;
      end
   end

   always_comb begin
      state_nxt       = state;
      pc_nxt          = pc;
      prog_len_nxt    = prog_len;
      read_file_nxt   = read_file;
      read_memory_nxt = read_memory;
      pos_nxt         = pos;
      instr_valid_nxt = instr_valid;
      instr_out_nxt   = instr_out;
      instr_pc_nxt    = instr_pc;
      done_nxt        = done;
      pc_err_nxt      = pc_err;
      // One bit wider than pc so the bounds check sees pc+1 without wrapping
      next_pc = branch_en ? {1'b0, branch_target} : {1'b0, pc} + 1'b1;

      case (state)
         LOAD: begin
            if (!read_file) begin
               read_file_nxt = 1'b1;
            end else if (fin_file || prog_len == LAST_WORD) begin
               if (!fin_file) begin
                  prog_len_nxt = FULL_LEN;
                  pc_err_nxt   = 1'b1;
               end
               read_file_nxt   = 1'b0;
               read_memory_nxt = 1'b1;
               pos_nxt         = '0;
               pc_nxt          = '0;
               state_nxt       = REQ;
            end else begin
               prog_len_nxt = prog_len + 1'b1;
            end
         end
         REQ, CAP, VALID: begin
            if (halt) begin
               read_memory_nxt = 1'b0;
               instr_valid_nxt = 1'b0;
               done_nxt        = 1'b1;
               state_nxt       = DONE;
            end else if (state == REQ) begin
               read_memory_nxt = 1'b0;
               state_nxt       = CAP;
            end else if (state == CAP) begin
               instr_out_nxt   = return_instr_line;
               instr_pc_nxt    = pc;
               instr_valid_nxt = 1'b1;
               state_nxt       = VALID;
            end else if (instr_valid && instr_ready) begin
               instr_valid_nxt = 1'b0;
               if (next_pc >= {1'b0, prog_len}) begin
                  done_nxt  = 1'b1;
                  state_nxt = DONE;
                  if (branch_en) pc_err_nxt = 1'b1;
               end else begin
                  pc_nxt          = next_pc[ADDR_W-1:0];
                  pos_nxt         = next_pc[ADDR_W-1:0];
                  read_memory_nxt = 1'b1;
                  state_nxt       = REQ;
               end
            end
         end
         DONE: ;
         default: state_nxt = LOAD;
      endcase
   end

endmodule

// File: tb/tb_instr_fetch_ctrl.sv
// Directed bench for instr_fetch_ctrl with a behavioural file/memory model.
module tb_instr_fetch_ctrl;
   localparam int AW = 9;
   localparam int IW = 16;

   logic          clk, rst, fin_file;
   logic [IW-1:0] return_instr_line;
   logic          read_file, read_memory;
   logic [AW-1:0] pos;
   logic          branch_en;
   logic [AW-1:0] branch_target;
   logic          halt, instr_ready, instr_valid;
   logic [IW-1:0] instr_out;
   logic [AW-1:0] instr_pc, prog_len;
   logic          done, pc_err;

   int errors = 0;
   int checks = 0;
   int file_len = 5;
   int load_cnt;
   int cyc = 0;
   int both_hi = 0;
   logic [IW-1:0] mem [0:511];

   instr_fetch_ctrl #(.ADDR_W(AW), .INSTR_W(IW), .MEM_DEPTH(400)) dut (
      .clk(clk), .rst(rst), .fin_file(fin_file), .return_instr_line(return_instr_line),
      .read_file(read_file), .read_memory(read_memory), .pos(pos),
      .branch_en(branch_en), .branch_target(branch_target), .halt(halt),
      .instr_ready(instr_ready), .instr_valid(instr_valid), .instr_out(instr_out),
      .instr_pc(instr_pc), .prog_len(prog_len), .done(done), .pc_err(pc_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // file loader: raises fin_file (registered) after file_len read_file edges
   always @(posedge clk or negedge rst) begin
      if (!rst) begin
         load_cnt <= 0;
         fin_file <= 1'b0;
      end else if (read_file) begin
         load_cnt <= load_cnt + 1;
         fin_file <= (load_cnt + 1 >= file_len);
      end
   end

   always @(posedge clk) begin
      cyc <= cyc + 1;
      if (read_memory) return_instr_line <= mem[pos];
   end

   always @(negedge clk) if (read_file && read_memory) both_hi <= both_hi + 1;

   task automatic load_prog(input int n);
      int w;
      file_len = n;
      rst = 1'b0;
      @(negedge clk);
      rst = 1'b1;
      w = 0;
      do begin
         @(negedge clk);
         w++;
      end while (!read_memory && w < n + 20);
      if (!read_memory) begin
         checks++; errors++;
         $display("FAIL load_timeout: read_memory never rose after %0d cycles", w);
      end
   endtask

   task automatic wait_valid(input int bound);
      int w;
      w = 0;
      do begin
         @(negedge clk);
         w++;
      end while (!instr_valid && w < bound);
      if (!instr_valid) begin
         checks++; errors++;
         $display("FAIL valid_timeout: instr_valid low for %0d cycles", w);
      end
   endtask

   task automatic test_reset();
      rst = 1'b0;
      #1;
      checks++;
      if ({read_file, read_memory, pos, instr_valid, instr_out, instr_pc, done, pc_err, prog_len} !== '0) begin
         errors++;
         $display("FAIL reset_outputs: rf=%b rm=%b pos=%0d v=%b out=%h pc=%0d done=%b err=%b len=%0d, want all 0",
                  read_file, read_memory, pos, instr_valid, instr_out, instr_pc, done, pc_err, prog_len);
      end
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      checks++;
      if (read_file !== 1'b1 || prog_len !== 9'd0) begin
         errors++;
         $display("FAIL reset_first_edge: read_file=%b prog_len=%0d, want 1 0", read_file, prog_len);
      end
   endtask

   task automatic test_load();
      int hi, w;
      file_len = 5;
      rst = 1'b0;
      @(negedge clk);
      rst = 1'b1;
      hi = 0;
      w = 0;
      do begin
         @(negedge clk);
         w++;
         if (read_file) hi++;
      end while (!read_memory && w < 40);
      checks++;
      if (hi != 6) begin
         errors++;
         $display("FAIL load_read_file_cycles: got %0d, want 6", hi);
      end
      checks++;
      if (prog_len !== 9'd5 || read_memory !== 1'b1 || pos !== 9'd0 || read_file !== 1'b0 || pc_err !== 1'b0) begin
         errors++;
         $display("FAIL load_first_req: len=%0d rm=%b pos=%0d rf=%b err=%b, want 5 1 0 0 0",
                  prog_len, read_memory, pos, read_file, pc_err);
      end
   endtask

   task automatic test_overflow();
      int w;
      for (int k = 0; k < 2; k++) begin
         file_len = (k == 0) ? 1000 : 399;
         halt = 1'b1;
         rst = 1'b0;
         @(negedge clk);
         rst = 1'b1;
         w = 0;
         do begin
            @(negedge clk);
            w++;
            if (w == 50) halt = 1'b0;
         end while (!read_memory && w < 450);
         checks++;
         if (k == 0 && (prog_len !== 9'd400 || pc_err !== 1'b1 || done !== 1'b0 || read_memory !== 1'b1)) begin
            errors++;
            $display("FAIL load_overflow: len=%0d err=%b done=%b rm=%b, want 400 1 0 1", prog_len, pc_err, done, read_memory);
         end else if (k == 1 && (prog_len !== 9'd399 || pc_err !== 1'b0 || read_memory !== 1'b1)) begin
            errors++;
            $display("FAIL load_fin_vs_overflow: len=%0d err=%b rm=%b, want 399 0 1", prog_len, pc_err, read_memory);
         end
      end
   endtask

   task automatic test_sequential();
      int prev;
      logic [IW-1:0] exp_w;
      instr_ready = 1'b1;
      load_prog(5);
      prev = 0;
      for (int p = 0; p < 5; p++) begin
         wait_valid(10);
         exp_w = 16'h1111 * 16'(p + 1);
         checks++;
         if (instr_pc !== 9'(p) || instr_out !== exp_w) begin
            errors++;
            $display("FAIL seq_word: pc=%0d out=%h, want %0d %h", instr_pc, instr_out, p, exp_w);
         end
         if (p > 0) begin
            checks++;
            if (cyc - prev != 3) begin
               errors++;
               $display("FAIL seq_spacing: %0d cycles between valids, want 3", cyc - prev);
            end
         end
         prev = cyc;
      end
      @(negedge clk);
      checks++;
      if (done !== 1'b1 || pc_err !== 1'b0 || instr_valid !== 1'b0 || read_memory !== 1'b0) begin
         errors++;
         $display("FAIL seq_done: done=%b err=%b v=%b rm=%b, want 1 0 0 0", done, pc_err, instr_valid, read_memory);
      end
   endtask

   task automatic test_backpressure();
      instr_ready = 1'b1;
      load_prog(5);
      for (int p = 0; p < 3; p++) wait_valid(10);
      instr_ready = 1'b0;
      for (int c = 0; c < 4; c++) begin
         checks++;
         if (instr_valid !== 1'b1 || instr_out !== 16'h3333 || instr_pc !== 9'd2 || read_memory !== 1'b0) begin
            errors++;
            $display("FAIL bp_hold: v=%b out=%h pc=%0d rm=%b, want 1 3333 2 0", instr_valid, instr_out, instr_pc, read_memory);
         end
         @(negedge clk);
      end
      instr_ready = 1'b1;
      @(negedge clk);
      checks++;
      if (instr_valid !== 1'b0 || read_memory !== 1'b1 || pos !== 9'd3) begin
         errors++;
         $display("FAIL bp_release: v=%b rm=%b pos=%0d, want 0 1 3", instr_valid, read_memory, pos);
      end
   endtask

   task automatic test_branch();
      instr_ready = 1'b1;
      load_prog(5);
      wait_valid(10);
      wait_valid(10);
      branch_en = 1'b1;
      branch_target = 9'd4;
      @(negedge clk);
      branch_en = 1'b0;
      checks++;
      if (read_memory !== 1'b1 || pos !== 9'd4) begin
         errors++;
         $display("FAIL branch_pos: rm=%b pos=%0d, want 1 4", read_memory, pos);
      end
      wait_valid(10);
      checks++;
      if (instr_pc !== 9'd4 || instr_out !== 16'h5555) begin
         errors++;
         $display("FAIL branch_word: pc=%0d out=%h, want 4 5555", instr_pc, instr_out);
      end
      @(negedge clk);
      checks++;
      if (done !== 1'b1 || pc_err !== 1'b0) begin
         errors++;
         $display("FAIL branch_end: done=%b err=%b, want 1 0", done, pc_err);
      end

      load_prog(5);
      wait_valid(10);
      wait_valid(10);
      branch_en = 1'b1;
      branch_target = 9'd7;
      @(negedge clk);
      branch_en = 1'b0;
      checks++;
      if (done !== 1'b1 || pc_err !== 1'b1 || read_memory !== 1'b0 || instr_valid !== 1'b0) begin
         errors++;
         $display("FAIL branch_range: done=%b err=%b rm=%b v=%b, want 1 1 0 0", done, pc_err, read_memory, instr_valid);
      end
   endtask

   task automatic test_halt();
      int seen;
      instr_ready = 1'b1;
      load_prog(5);
      for (int p = 0; p < 3; p++) wait_valid(10);
      @(negedge clk);
      @(negedge clk);
      halt = 1'b1;
      @(negedge clk);
      halt = 1'b0;
      checks++;
      if (done !== 1'b1 || instr_valid !== 1'b0 || read_memory !== 1'b0) begin
         errors++;
         $display("FAIL halt_done: done=%b v=%b rm=%b, want 1 0 0", done, instr_valid, read_memory);
      end
      seen = 0;
      for (int c = 0; c < 6; c++) begin
         @(negedge clk);
         if (instr_valid || read_memory || !done) seen++;
      end
      checks++;
      if (seen != 0) begin
         errors++;
         $display("FAIL halt_terminal: %0d cycles left DONE, want 0", seen);
      end
   endtask

   task automatic test_reset_mid();
      instr_ready = 1'b0;
      load_prog(5);
      wait_valid(10);
      #2;
      rst = 1'b0;
      #1;
      checks++;
      if ({read_file, read_memory, pos, instr_valid, instr_out, instr_pc, done, pc_err, prog_len} !== '0) begin
         errors++;
         $display("FAIL reset_mid_outputs: rf=%b rm=%b v=%b out=%h pc=%0d done=%b err=%b len=%0d, want all 0",
                  read_file, read_memory, instr_valid, instr_out, instr_pc, done, pc_err, prog_len);
      end
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      checks++;
      if (read_file !== 1'b1 || read_memory !== 1'b0 || instr_valid !== 1'b0) begin
         errors++;
         $display("FAIL reset_mid_restart: rf=%b rm=%b v=%b, want 1 0 0", read_file, read_memory, instr_valid);
      end
   endtask

   initial begin
      for (int i = 0; i < 512; i++)
         mem[i] = (i < 5) ? 16'h1111 * 16'(i + 1) : 16'hA000 + 16'(i);
      rst = 1'b0;
      branch_en = 1'b0;
      branch_target = '0;
      halt = 1'b0;
      instr_ready = 1'b0;
      test_reset();
      test_load();
      test_sequential();
      test_backpressure();
      test_branch();
      test_halt();
      test_overflow();
      test_reset_mid();
      checks++;
      if (both_hi != 0) begin
         errors++;
         $display("FAIL strobe_exclusive: read_file and read_memory both high %0d cycles, want 0", both_hi);
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule

// File: doc/instr_fetch_ctrl.md
Name: instr_fetch_ctrl

Overview:
- Fetch controller directly downstream of the instruction memory.
- After reset it drives the memory's file-load phase until the memory reports end of file, and records the program length.
- It then sequences reads through the memory's 1-cycle registered read port and presents each instruction to decode with a valid/ready handshake.
- It also handles branch redirect, halt and out-of-range program counter.

Parameters:
- ADDR_W, 9: program counter and memory address width.
- INSTR_W, 16: instruction word width.
- MEM_DEPTH, 400: memory capacity in words; the load phase stops here.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous active-low reset.
- fin_file  in  1  end-of-file flag from memory (registered there).
- return_instr_line  in  INSTR_W  memory read data; valid the cycle after a read_memory edge.
- read_file  out  1  memory load-from-file strobe.
- read_memory  out  1  memory read strobe.
- pos  out  ADDR_W  memory read address.
- branch_en  in  1  redirect request; sampled only on a handshake edge.
- branch_target  in  ADDR_W  redirect address.
- halt  in  1  stop fetching (decode saw HALT).
- instr_ready  in  1  decode accepts instr_out.
- instr_valid  out  1  instr_out/instr_pc valid.
- instr_out  out  INSTR_W  fetched instruction.
- instr_pc  out  ADDR_W  address of instr_out.
- prog_len  out  ADDR_W  number of words loaded.
- done  out  1  fetch finished (halt or end of program).
- pc_err  out  1  sticky: branch target >= prog_len, or load overflowed MEM_DEPTH.

Behaviour:
- Reset (rst low, asynchronous):
  - state=LOAD, pc=0, prog_len=0.
  - All outputs 0: read_file, read_memory, pos, instr_valid, instr_out, instr_pc, done, pc_err.
  - Reset mid-operation aborts everything and restarts at LOAD.
- All outputs are registered.
- LOAD:
  - read_file=1.
  - Each clock edge in LOAD with read_file=1 increments prog_len.
  - When fin_file is sampled 1: read_file<=0, state<=REQ, pc<=0.
  - If prog_len reaches MEM_DEPTH before fin_file: read_file<=0, pc_err<=1, state<=REQ.
- REQ:
  - read_memory=1, pos=pc; the next edge moves to CAP.
  - The memory latches data on that same edge.
- CAP:
  - read_memory=0.
  - On the edge: instr_out<=return_instr_line, instr_pc<=pc, instr_valid<=1, state<=VALID.
- VALID:
  - instr_valid held 1; instr_out/instr_pc stable until handshake (instr_valid & instr_ready at the edge).
  - On handshake: instr_valid<=0, next_pc = branch_en ? branch_target : pc+1.
  - If next_pc >= prog_len: state<=DONE. If additionally branch_en, pc_err<=1 (a sequential fall-off is a normal end).
  - Otherwise pc<=next_pc, state<=REQ.
- Throughput: 3 cycles per instruction minimum (REQ, CAP, VALID with ready=1).
- DONE: done=1, read_memory=0, instr_valid=0; terminal until reset.
- halt:
  - Sampled in REQ/CAP/VALID; takes priority over the handshake.
  - Next state DONE; instr_valid<=0 on the same edge (an instruction offered that cycle is dropped).
  - Ignored in LOAD.
- Simultaneous fin_file and overflow: fin_file wins, pc_err stays 0.
- pc arithmetic is ADDR_W-bit unsigned. The bounds check uses the full pc+1 value, so no wrap is ever fetched.
- read_file and read_memory are never both 1.

Test Plan:
- Load 5 words: assert fin_file after the 5th read_file edge -> prog_len=5, read_file drops the cycle after, first REQ with pos=0.
- Sequential fetch, instr_ready=1 constant, memory words 0x1111..0x5555 -> instr_valid pulses every 3 cycles with pc 0..4 in order; done=1 after pc 4 handshake; pc_err=0.
- Backpressure: ready=0 for 4 cycles at pc=2 -> instr_out=0x3333 and instr_pc=2 held stable; read_memory stays 0 until the handshake.
- Branch: on handshake at pc=1 with branch_en=1, target=4 -> next REQ pos=4. With target=7 (prog_len=5) -> DONE and pc_err=1.
- Halt asserted in CAP at pc=3 -> DONE next edge, no instr_valid for pc 3, done=1.
- Reset low mid-VALID -> all outputs 0 immediately, state LOAD with read_file=1 on the first edge after release.
